// File: rtl/bcd_display_ctrl.sv
// bcd_display_ctrl: double-dabble binary-to-BCD converter feeding a
// multiplexed 4-digit 7-segment display with optional leading-zero blanking.
module bcd_display_ctrl #(
  parameter int BIN_LENGTH = 10,
  parameter int SCAN_DIV = 4,
  parameter bit BLANK = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_LENGTH-1:0] bin,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           bcd,
  output logic                  overflow,
  output logic [6:0]            seg,
  output logic [3:0]            an
);
  localparam int CW = $clog2(BIN_LENGTH + 1);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [BIN_LENGTH-1:0] op;
  logic [15:0] scr, scr_n;
  logic [14:0] adj;
  logic [CW-1:0] cnt;
  logic big;
  logic [SW-1:0] scnt;
  logic [1:0] dig;
  logic [3:0] nib;
  logic blank;
  for (genvar g = 0; g < 3; g++) begin : g_adj
    assign adj[4*g +: 4] = scr[4*g +: 4] > 4'd4 ? scr[4*g +: 4] + 4'd3 : scr[4*g +: 4];
  end
  // The top nibble's carry-out is shifted away, so only its low 3 bits matter.
  assign adj[14:12] = scr[15:12] > 4'd4 ? 3'(scr[15:12] + 4'd3) : scr[14:12];
  assign scr_n = {adj, op[BIN_LENGTH-1]};
  assign state_n = state == IDLE ? (start ? SHIFT : IDLE) :
                   state == SHIFT ? (cnt == CW'(1) ? DONE : SHIFT) : IDLE;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op <= '0;
      scr <= '0;
      cnt <= '0;
      big <= 1'b0;
      bcd <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        op <= bin;
        scr <= '0;
        cnt <= CW'(BIN_LENGTH);
        big <= 32'(bin) > 32'd9999;
      end else if (state == SHIFT) begin
        scr <= scr_n;
        op <= op << 1;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          bcd <= big ? 16'h9999 : scr_n;
          overflow <= big;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      scnt <= '0;
      dig <= '0;
    end else begin
      scnt <= scnt == SW'(SCAN_DIV - 1) ? '0 : scnt + 1'b1;
      if (scnt == SW'(SCAN_DIV - 1)) dig <= dig + 1'b1;
    end
  end
  assign an = 4'b0001 << dig;
  assign nib = bcd[{dig, 2'b00} +: 4];
  assign blank = BLANK && (dig == 2'd3 ? bcd[15:12] == '0 :
                           dig == 2'd2 ? bcd[15:8] == '0 :
                           dig == 2'd1 ? bcd[15:4] == '0 : 1'b0);
  always_comb begin
    seg = 7'b0111111;
    case (nib)
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1100111;
      default: seg = 7'b0111111;
    endcase
    if (blank) seg = 7'b0000000;
  end
endmodule

// File: doc/bcd_display_ctrl.md
BCD_DISPLAY_CTRL -- requirements
Module: bcd_display_ctrl

Interface
REQ-001 Parameter BIN_LENGTH, default 10, is the binary input width; legal range 4..14.
REQ-002 Parameter SCAN_DIV, default 4, is the number of clocks each digit is enabled; legal minimum 1.
REQ-003 Parameter BLANK, default 1; when 1, leading-zero blanking is on.
REQ-004 The block has one clock and a synchronous, active-high reset.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  conversion request, sampled every edge.
REQ-008 bin  in  BIN_LENGTH  unsigned binary operand, sampled with start.
REQ-009 busy  out  1  high while a conversion is in progress or completing.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 bcd  out  16  result digits {thousands,hundreds,tens,ones}, 4 bits each.
REQ-012 overflow  out  1  last accepted operand exceeded 9999.
REQ-013 seg  out  7  segments of the currently scanned digit, active-high, bit0=a..bit6=g.
REQ-014 an  out  4  one-hot, active-high digit enable; bit i selects bcd[4i+3:4i].

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 In IDLE with start=1, the block SHALL capture bin, clear the 16-bit scratch register, load the shift count with BIN_LENGTH, and enter SHIFT.
REQ-017 Each SHIFT edge SHALL perform one double-dabble step:
- add 3 to every scratch nibble whose value is >4;
- shift {scratch,operand} left by 1;
- decrement the count.
REQ-018 After the BIN_LENGTH-th shift, the block SHALL load the final scratch into bcd and enter DONE.
REQ-019 Latency: for start accepted at edge k, bcd SHALL update at edge k+BIN_LENGTH, and done SHALL be high for exactly the cycle following that edge.
REQ-020 DONE SHALL return to IDLE unconditionally on the next edge.
REQ-021 busy SHALL equal (state != IDLE).
REQ-022 done SHALL equal (state == DONE).
REQ-023 start SHALL be ignored in SHIFT and DONE; neither the captured operand nor the result is affected.
REQ-024 The earliest next accept SHALL be one cycle after done, giving a start-to-start period of BIN_LENGTH+2 cycles.
REQ-025 If the captured operand is >9999, then at the DONE load bcd SHALL be 16'h9999 and overflow=1.
REQ-026 Otherwise, at the DONE load overflow=0.
REQ-027 bcd and overflow SHALL hold their values between conversions.
REQ-028 A free-running scan counter SHALL count 0..SCAN_DIV-1 and wrap.
REQ-029 The digit index SHALL advance by 1 on each scan wrap, with 3 wrapping to 0.
REQ-030 The scan SHALL run independently of the FSM state.
REQ-031 an SHALL be the one-hot decode of the digit index.
REQ-032 seg encoding SHALL be:
- 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110;
- 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1100111;
- values 10-15 show 0111111.
REQ-033 With BLANK=1, digit i (i=3..1) SHALL output seg=0000000 when it and all higher digits are 0.
REQ-034 Digit 0 SHALL never be blanked.
REQ-035 seg SHALL show the bcd output register, never the scratch register, so the display shows no intermediate values.
REQ-036 Simultaneous rst and start SHALL give reset priority; the start is discarded.

Reset
REQ-037 When rst=1, the following SHALL take effect at the clock edge:
- state=IDLE;
- bcd=16'h0000, overflow=0, busy=0, done=0;
- scan counter=0, digit index=0, an=0001, seg=0111111.
REQ-038 Reset during SHIFT SHALL abort the conversion: no done pulse, and bcd SHALL be cleared rather than partially updated.

Verification
REQ-039 After reset, with BIN_LENGTH=10 and bin=0 with start at edge k: done SHALL be high exactly the cycle after edge k+10, bcd SHALL be 0x0000, and digit-0 seg SHALL be 0111111.
REQ-040 With bin=1023: bcd SHALL be 0x1023, overflow=0, and done SHALL be high for one cycle only.
REQ-041 With bin=500 accepted, then start with bin=7 during SHIFT and again during DONE: the result SHALL be 0x0500, and no second done pulse SHALL occur.
REQ-042 With rst on the 5th SHIFT edge: no done pulse SHALL occur and bcd SHALL be 0x0000. A following start with bin=999 SHALL give bcd=0x0999; with BLANK=1, seg on an=1000 SHALL be 0000000.
REQ-043 With SCAN_DIV=4 from reset, an SHALL be 0001 for 4 cycles, then 0010, 0100 and 1000 (4 cycles each), then wrap to 0001.
REQ-044 With BIN_LENGTH=14 and bin=12345: overflow SHALL be 1 and bcd SHALL be 0x9999. A following bin=42 SHALL give overflow=0 and bcd=0x0042.
